bin_to_bcd_seq: RTL

- Sequential double-dabble converter: unsigned binary in, packed BCD out (one nibble per decimal digit).
- Sits directly upstream of the 4-digit seven-segment display driver; bcd_o connects straight to the driver's 16-bit data_i, so the display shows decimal instead of hex.
- Converts one input bit per clock under a start/valid handshake.

---
 rtl/bin_to_bcd_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD; define BCD_SATURATE_EN to clamp overflowing results to all nines
module bin_to_bcd_seq #(
   parameter int IN_W   = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [IN_W-1:0]       bin_i,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  valid_o,
   output logic                  busy_o,
   output logic                  ovf_o
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SH_W  = BCD_W + IN_W;
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam longint unsigned  BCD_MAX  = (64'd10 ** DIGITS) - 64'd1;
`ifdef BCD_SATURATE_EN
   localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [SH_W-1:0]    shreg;
   logic [SH_W-1:0]    corrected;
   logic [SH_W-1:0]    shifted;
   logic [BCD_W-1:0]   bcd_next;
   logic [CNT_W-1:0]   count;
   logic               ovf_flag;
   logic               bin_ovf;
   logic               load;
   logic               last;

   assign bin_ovf = 64'(bin_i) > BCD_MAX;
   assign load    = start_i && (state != SHIFT);
   assign last    = (state == SHIFT) && (count == CNT_ONE);
   assign shifted = corrected << 1;

   // Add 3 to every BCD nibble of 5 or more before this edge's shift
   always_comb begin
      corrected = shreg;
      for (int d = 0; d < DIGITS; d++) begin
         if (shreg[IN_W + 4*d +: 4] >= 4'd5) begin
            corrected[IN_W + 4*d +: 4] = shreg[IN_W + 4*d +: 4] + 4'd3;
         end
      end
   end

   // Select the value published on completion; top bit shifted out is dropped
   always_comb begin
`ifdef BCD_SATURATE_EN
      bcd_next = ovf_flag ? ALL_NINES : shifted[SH_W-1 -: BCD_W];
`else
      bcd_next = shifted[SH_W-1 -: BCD_W];
`endif
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: accept from IDLE or DONE, leave SHIFT on the last bit
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start_i ? SHIFT : IDLE;
         SHIFT:   state_nxt = (count == CNT_ONE) ? DONE : SHIFT;
         DONE:    state_nxt = start_i ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from state; valid lasts exactly the DONE cycle
   always_comb begin
      busy_o  = 1'b0;
      valid_o = 1'b0;
      case (state)
         SHIFT:   busy_o  = 1'b1;
         DONE:    valid_o = 1'b1;
         default: begin
            busy_o  = 1'b0;
            valid_o = 1'b0;
         end
      endcase
   end

   // Datapath: load on accept, shift one bit per cycle, publish on the final shift
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         shreg    <= '0;
         count    <= '0;
         ovf_flag <= 1'b0;
         bcd_o    <= '0;
         ovf_o    <= 1'b0;
      end else if (load) begin
         shreg    <= {{BCD_W{1'b0}}, bin_i};
         count    <= CNT_LOAD;
         ovf_flag <= bin_ovf;
      end else if (state == SHIFT) begin
         shreg <= shifted;
         count <= count - CNT_ONE;
         if (last) begin
            bcd_o <= bcd_next;
            ovf_o <= ovf_flag;
         end
      end
   end

endmodule
